ov5640_i2c_arb: RTL and testbench

// - Shares the single OV5640 SCCB/I2C master between two requesters, which otherwise could not both drive it.
// - Port 0: the power-up register-table sequencer. Port 1: runtime access (exposure/AWB/AF tweaks, register readback).
// - Sits between the requesters and the I2C master, clocked by the master's dri_clk.
// - Latches one pending transaction per port, arbitrates, issues one exec pulse, returns the done and read data.

---
 rtl/ov5640_pkg.sv | 27 ++
 rtl/ov5640_arb_slot.sv | 86 ++++++++
 rtl/ov5640_i2c_arb.sv | 222 ++++++++++++++++++++++
 tb/tb_ov5640_i2c_arb.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov5640_pkg.sv
// ---------------------------------------------------------------------------
// ov5640_pkg
// Shared definitions for the OV5640 SCCB/I2C master arbiter.
//   - FSM state encoding (2 bits) and the state enum built on it
//   - command field widths (16-bit register address, 8-bit data)
//   - default WAIT timeout, only used when OV5640_ARB_TIMEOUT_EN is defined
// ---------------------------------------------------------------------------
package ov5640_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  localparam logic [15:0] TIMEOUT_DEFAULT = 16'd20000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_WAIT  = ST_WAIT,
    S_DONE  = ST_DONE
  } arb_state_e;

endpackage

// File: rtl/ov5640_arb_slot.sv
// ---------------------------------------------------------------------------
// ov5640_arb_slot
// One-deep command latch for one requester port of the OV5640 I2C arbiter.
// A start pulse while the slot is empty captures the command; a start pulse
// while it is full is dropped and reported one cycle later on err_o.
//
// Ports
//   clk, rst       clock / asynchronous active-high reset
//   exec_i         requester start pulse, command fields sampled with it
//   addr_i         16-bit register address
//   wdata_i        8-bit write data
//   rh_wl_i        1 = read, 0 = write
//   clear_i        transaction of this slot finished, empty the slot
//   busy_o         slot holds a pending or in-flight command
//   err_o          1-cycle pulse: start pulse dropped because slot was full
//   addr_o/wdata_o/rh_wl_o  latched command
// ---------------------------------------------------------------------------
module ov5640_arb_slot
  import ov5640_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              exec_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              rh_wl_i,
  input  logic              clear_i,
  output logic              busy_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              rh_wl_o
);

  logic              full_q,  full_d;
  logic              err_q,   err_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rh_wl_q, rh_wl_d;

  // A start pulse is judged against the registered full flag, so a pulse in
  // the same cycle as clear_i is still dropped; the owner sees busy_o=1 then.
  always_comb begin
    full_d  = full_q;
    err_d   = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rh_wl_d = rh_wl_q;
    if (clear_i) begin
      full_d = 1'b0;
    end
    if (exec_i) begin
      if (full_q) begin
        err_d = 1'b1;
      end else begin
        full_d  = 1'b1;
        addr_d  = addr_i;
        wdata_d = wdata_i;
        rh_wl_d = rh_wl_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rh_wl_q <= 1'b0;
    end else begin
      full_q  <= full_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rh_wl_q <= rh_wl_d;
    end
  end

  assign busy_o  = full_q;
  assign err_o   = err_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign rh_wl_o = rh_wl_q;

endmodule

// File: rtl/ov5640_i2c_arb.sv
// ---------------------------------------------------------------------------
// ov5640_i2c_arb
// Shares one OV5640 SCCB/I2C master between two requesters:
//   port 0 = power-up register-table sequencer, port 1 = runtime access.
// Each port owns a one-deep command slot; the FSM picks a full slot, issues
// one i2c_exec pulse, waits for i2c_done and returns done / read data.
//
// Optional feature: define OV5640_ARB_TIMEOUT_EN to bound the WAIT state to
// TIMEOUT_CYC cycles; on expiry the granted port gets err + done, rdata=0.
//
// Parameters
//   PRIO_INIT    1: port 0 strict priority while init_done_i=0, then RR
//                0: always round-robin
//   TIMEOUT_CYC  WAIT cycles before a timeout (timeout build only)
//
// Ports
//   clk, rst                 dri_clk of the master / async active-high reset
//   init_done_i              register table complete (level)
//   pX_exec_i                start pulse, pX_addr_i/pX_wdata_i/pX_rh_wl_i
//                            sampled with it
//   pX_busy_o                command pending or in flight
//   pX_done_o                1-cycle completion pulse
//   pX_rdata_o               read data, valid with pX_done_o, held after
//   pX_err_o                 1-cycle pulse: dropped start or timeout
//   i2c_exec_o               1-cycle start pulse to the master
//   i2c_addr_o/i2c_data_w_o/i2c_rh_wl_o  command, stable from exec to done
//   i2c_done_i, i2c_data_r_i completion pulse and read data from the master
//   dbg_state_o              current FSM state (ST_* encoding)
//
// Handshake: every exec/done signal is a single-cycle pulse; a requester may
// pulse pX_exec_i whenever pX_busy_o=0 and it is accepted at that edge.
// ---------------------------------------------------------------------------
module ov5640_i2c_arb
  import ov5640_pkg::*;
#(
  parameter int          PRIO_INIT   = 1,
  parameter logic [15:0] TIMEOUT_CYC = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_done_i,
  input  logic        p0_exec_i,
  input  logic [15:0] p0_addr_i,
  input  logic [7:0]  p0_wdata_i,
  input  logic        p0_rh_wl_i,
  output logic        p0_busy_o,
  output logic        p0_done_o,
  output logic [7:0]  p0_rdata_o,
  output logic        p0_err_o,
  input  logic        p1_exec_i,
  input  logic [15:0] p1_addr_i,
  input  logic [7:0]  p1_wdata_i,
  input  logic        p1_rh_wl_i,
  output logic        p1_busy_o,
  output logic        p1_done_o,
  output logic [7:0]  p1_rdata_o,
  output logic        p1_err_o,
  output logic        i2c_exec_o,
  output logic [15:0] i2c_addr_o,
  output logic [7:0]  i2c_data_w_o,
  output logic        i2c_rh_wl_o,
  input  logic        i2c_done_i,
  input  logic [7:0]  i2c_data_r_i,
  output logic [1:0]  dbg_state_o
);

  arb_state_e state_q, state_d;
  logic       grant_q, grant_d;   // 0 = port 0, 1 = port 1
  logic       rr_q,    rr_d;      // port preferred on the next contended grant
  logic       to_q,    to_d;      // current completion is a timeout
  logic [7:0] p0_rdata_q, p0_rdata_d;
  logic [7:0] p1_rdata_q, p1_rdata_d;
  logic       finish;
  logic       timeout;
  logic       prio_active;
  logic       cmd_active;

  logic              s0_busy, s0_err, s0_rh_wl;
  logic [ADDR_W-1:0] s0_addr;
  logic [DATA_W-1:0] s0_wdata;
  logic              s1_busy, s1_err, s1_rh_wl;
  logic [ADDR_W-1:0] s1_addr;
  logic [DATA_W-1:0] s1_wdata;

  // The slot is released on the edge that leaves WAIT, so busy is already low
  // during DONE and a new start pulse from that port is accepted there.
  ov5640_arb_slot u_slot0 (
    .clk     (clk),
    .rst     (rst),
    .exec_i  (p0_exec_i),
    .addr_i  (p0_addr_i),
    .wdata_i (p0_wdata_i),
    .rh_wl_i (p0_rh_wl_i),
    .clear_i (finish & ~grant_q),
    .busy_o  (s0_busy),
    .err_o   (s0_err),
    .addr_o  (s0_addr),
    .wdata_o (s0_wdata),
    .rh_wl_o (s0_rh_wl)
  );

  ov5640_arb_slot u_slot1 (
    .clk     (clk),
    .rst     (rst),
    .exec_i  (p1_exec_i),
    .addr_i  (p1_addr_i),
    .wdata_i (p1_wdata_i),
    .rh_wl_i (p1_rh_wl_i),
    .clear_i (finish & grant_q),
    .busy_o  (s1_busy),
    .err_o   (s1_err),
    .addr_o  (s1_addr),
    .wdata_o (s1_wdata),
    .rh_wl_o (s1_rh_wl)
  );

`ifdef OV5640_ARB_TIMEOUT_EN
  logic [15:0] to_cnt_q, to_cnt_d;

  // Counts WAIT cycles from 0; expiry is flagged in the TIMEOUT_CYC-th one.
  assign to_cnt_d = (state_q == S_WAIT) ? to_cnt_q + 16'd1 : 16'd0;
  assign timeout  = (state_q == S_WAIT) && (to_cnt_q == TIMEOUT_CYC - 16'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= 16'd0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timeout            = 1'b0;
`endif

  assign prio_active = (PRIO_INIT != 0) && !init_done_i;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    to_d       = to_q;
    finish     = 1'b0;
    p0_rdata_d = p0_rdata_q;
    p1_rdata_d = p1_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (s0_busy || s1_busy) begin
          state_d = S_ISSUE;
          to_d    = 1'b0;
          // The pointer only moves when it actually resolved a contention in
          // round-robin mode; a lone requester or a priority grant leaves it.
          if (s0_busy && s1_busy && !prio_active) begin
            grant_d = rr_q;
            rr_d    = ~rr_q;
          end else begin
            grant_d = ~s0_busy;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i2c_done_i || timeout) begin
          state_d = S_DONE;
          finish  = 1'b1;
          to_d    = ~i2c_done_i;
          if (grant_q) begin
            p1_rdata_d = i2c_done_i ? i2c_data_r_i : 8'h00;
          end else begin
            p0_rdata_d = i2c_done_i ? i2c_data_r_i : 8'h00;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      grant_q    <= 1'b0;
      rr_q       <= 1'b0;
      to_q       <= 1'b0;
      p0_rdata_q <= 8'h00;
      p1_rdata_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      to_q       <= to_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
    end
  end

  // Master-side command is driven only while a transaction is outstanding.
  assign cmd_active   = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign i2c_exec_o   = (state_q == S_ISSUE);
  assign i2c_addr_o   = cmd_active ? (grant_q ? s1_addr  : s0_addr)  : 16'h0000;
  assign i2c_data_w_o = cmd_active ? (grant_q ? s1_wdata : s0_wdata) : 8'h00;
  assign i2c_rh_wl_o  = cmd_active ? (grant_q ? s1_rh_wl : s0_rh_wl) : 1'b0;

  assign p0_busy_o  = s0_busy;
  assign p1_busy_o  = s1_busy;
  assign p0_done_o  = (state_q == S_DONE) && !grant_q;
  assign p1_done_o  = (state_q == S_DONE) &&  grant_q;
  assign p0_err_o   = s0_err | (p0_done_o & to_q);
  assign p1_err_o   = s1_err | (p1_done_o & to_q);
  assign p0_rdata_o = p0_rdata_q;
  assign p1_rdata_o = p1_rdata_q;

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ov5640_i2c_arb.sv
// ---------------------------------------------------------------------------
// tb_ov5640_i2c_arb
// Self-checking bench for ov5640_i2c_arb. The bench plays both requesters
// and the I2C master. Expected master-side commands are pushed to exp_q in
// the order the bench predicts the grants ({port, rh_wl, addr, wdata}) and
// popped when i2c_exec is seen. Define OV5640_ARB_TIMEOUT_EN to also cover
// the timeout path (TIMEOUT_CYC is set to 100 here).
// ---------------------------------------------------------------------------
module tb_ov5640_i2c_arb;

`ifdef OV5640_ARB_TIMEOUT_EN
  localparam logic [15:0] TB_TO = 16'd100;
`else
  localparam logic [15:0] TB_TO = 16'd20000;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        init_done;
  logic        p0_exec, p1_exec;
  logic [15:0] p0_addr, p1_addr;
  logic [7:0]  p0_wdata, p1_wdata;
  logic        p0_rh_wl, p1_rh_wl;
  logic        p0_busy, p0_done, p0_err, p1_busy, p1_done, p1_err;
  logic [7:0]  p0_rdata, p1_rdata;
  logic        i2c_exec, i2c_rh_wl, i2c_done;
  logic [15:0] i2c_addr;
  logic [7:0]  i2c_data_w, i2c_data_r;
  logic [1:0]  dbg_state;

  logic [25:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          exec_cnt = 0;
  bit          rr_m;

  ov5640_i2c_arb #(.PRIO_INIT(1), .TIMEOUT_CYC(TB_TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .init_done_i  (init_done),
    .p0_exec_i    (p0_exec),
    .p0_addr_i    (p0_addr),
    .p0_wdata_i   (p0_wdata),
    .p0_rh_wl_i   (p0_rh_wl),
    .p0_busy_o    (p0_busy),
    .p0_done_o    (p0_done),
    .p0_rdata_o   (p0_rdata),
    .p0_err_o     (p0_err),
    .p1_exec_i    (p1_exec),
    .p1_addr_i    (p1_addr),
    .p1_wdata_i   (p1_wdata),
    .p1_rh_wl_i   (p1_rh_wl),
    .p1_busy_o    (p1_busy),
    .p1_done_o    (p1_done),
    .p1_rdata_o   (p1_rdata),
    .p1_err_o     (p1_err),
    .i2c_exec_o   (i2c_exec),
    .i2c_addr_o   (i2c_addr),
    .i2c_data_w_o (i2c_data_w),
    .i2c_rh_wl_o  (i2c_rh_wl),
    .i2c_done_i   (i2c_done),
    .i2c_data_r_i (i2c_data_r),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (i2c_exec === 1'b1) exec_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic drive_cmd(input bit port, input logic [15:0] a, input logic [7:0] d,
                           input bit rh);
    if (port == 1'b0) begin
      p0_exec = 1'b1; p0_addr = a; p0_wdata = d; p0_rh_wl = rh;
    end else begin
      p1_exec = 1'b1; p1_addr = a; p1_wdata = d; p1_rh_wl = rh;
    end
  endtask

  task automatic clear_exec();
    p0_exec = 1'b0;
    p1_exec = 1'b0;
  endtask

  // One-cycle start pulse on one port, expectation queued.
  task automatic issue(input bit port, input logic [15:0] a, input logic [7:0] d,
                       input bit rh);
    @(posedge clk); #1;
    drive_cmd(port, a, d, rh);
    exp_q.push_back({port, rh, a, d});
    @(posedge clk); #1;
    clear_exec();
  endtask

  task automatic pop_exp(output logic [25:0] e);
    if (exp_q.size() == 0) e = 'x;
    else e = exp_q.pop_front();
  endtask

  // Waits (bounded) for i2c_exec; returns {rh_wl, addr, data_w} or X on expiry.
  // Ends at the falling edge inside the ISSUE cycle.
  task automatic wait_exec(output logic [24:0] seen);
    bit got;
    got  = 1'b0;
    seen = 'x;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (i2c_exec === 1'b1) begin
        got  = 1'b1;
        seen = {i2c_rh_wl, i2c_addr, i2c_data_w};
      end
    end
  endtask

  // Master model: done pulse lat cycles later; ends mid DONE cycle.
  task automatic finish_txn(input int lat, input logic [7:0] rd);
    repeat (lat) @(posedge clk);
    #1;
    i2c_done   = 1'b1;
    i2c_data_r = rd;
    @(posedge clk); #1;
    i2c_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic serve(input int lat, input logic [7:0] rd, output logic [24:0] seen);
    wait_exec(seen);
    finish_txn(lat, rd);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; init_done = 1'b0; i2c_done = 1'b0; i2c_data_r = 8'h00;
    clear_exec();
    p0_addr = '0; p0_wdata = '0; p0_rh_wl = 1'b0;
    p1_addr = '0; p1_wdata = '0; p1_rh_wl = 1'b0;
    rr_m = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({i2c_exec, p0_busy, p1_busy, p0_done, p1_done, p0_err, p1_err} !== 7'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000000",
                         {i2c_exec, p0_busy, p1_busy, p0_done, p1_done, p0_err, p1_err});
    end
    checks++;
    if ({i2c_rh_wl, i2c_addr, i2c_data_w, p0_rdata, p1_rdata} !== 41'h0) begin
      errors++; $display("FAIL reset_data: got %h expected 0",
                         {i2c_rh_wl, i2c_addr, i2c_data_w, p0_rdata, p1_rdata});
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state);
    end
    rst = 1'b0;
  endtask

  task automatic test_write();
    logic [25:0] e;
    logic [24:0] seen;
    @(posedge clk); #1;
    drive_cmd(1'b0, 16'h3008, 8'h82, 1'b0);
    exp_q.push_back({1'b0, 1'b0, 16'h3008, 8'h82});
    @(posedge clk); #1;
    clear_exec();
    @(negedge clk);
    checks++;
    if ({i2c_exec, p0_busy} !== 2'b01) begin
      errors++; $display("FAIL write_k1 exec/busy: got %b expected 01", {i2c_exec, p0_busy});
    end
    @(negedge clk);
    seen = {i2c_rh_wl, i2c_addr, i2c_data_w};
    pop_exp(e);
    checks++;
    if (i2c_exec !== 1'b1) begin
      errors++; $display("FAIL write_k2 exec: got %b expected 1", i2c_exec);
    end
    checks++;
    if (seen !== e[24:0]) begin
      errors++; $display("FAIL write_fields: got %h expected %h", seen, e[24:0]);
    end
    finish_txn(50, 8'hA5);
    checks++;
    if ({p0_done, p0_busy, p1_done, p0_rdata} !== {3'b100, 8'hA5}) begin
      errors++; $display("FAIL write_done: got %b_%h expected 100_a5",
                         {p0_done, p0_busy, p1_done}, p0_rdata);
    end
    @(negedge clk);
    checks++;
    if ({p0_done, dbg_state} !== 3'b000) begin
      errors++; $display("FAIL write_after: got %b expected 000", {p0_done, dbg_state});
    end
  endtask

  // Both ports start in the same cycle; the bench predicts the winner.
  task automatic test_arb(input bit init, input string name);
    logic [25:0] e;
    logic [24:0] seen;
    bit first;
    init_done = init;
    first = init ? rr_m : 1'b0;
    if (init) rr_m = ~rr_m;
    @(posedge clk); #1;
    drive_cmd(1'b0, 16'h3100, 8'h01, 1'b0);
    drive_cmd(1'b1, 16'h3200, 8'h02, 1'b0);
    if (first == 1'b0) begin
      exp_q.push_back({1'b0, 1'b0, 16'h3100, 8'h01});
      exp_q.push_back({1'b1, 1'b0, 16'h3200, 8'h02});
    end else begin
      exp_q.push_back({1'b1, 1'b0, 16'h3200, 8'h02});
      exp_q.push_back({1'b0, 1'b0, 16'h3100, 8'h01});
    end
    @(posedge clk); #1;
    clear_exec();
    for (int n = 0; n < 2; n++) begin
      serve(5, 8'h10 + 8'(n), seen);
      pop_exp(e);
      checks++;
      if (seen !== e[24:0]) begin
        errors++; $display("FAIL %s_order%0d: got %h expected %h", name, n, seen, e[24:0]);
      end
      checks++;
      if ({p1_done, p0_done} !== (e[25] ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL %s_done%0d: got %b expected port %0d",
                           name, n, {p1_done, p0_done}, e[25]);
      end
    end
  endtask

  task automatic test_read();
    logic [25:0] e;
    logic [24:0] seen;
    issue(1'b1, 16'h300A, 8'h00, 1'b1);
    serve(20, 8'h56, seen);
    pop_exp(e);
    checks++;
    if (seen !== e[24:0]) begin
      errors++; $display("FAIL read_fields: got %h expected %h", seen, e[24:0]);
    end
    checks++;
    if ({p1_done, p1_rdata} !== {1'b1, 8'h56}) begin
      errors++; $display("FAIL read_done: got %b_%h expected 1_56", p1_done, p1_rdata);
    end
    repeat (5) @(negedge clk);
    checks++;
    if ({p1_done, p1_rdata} !== {1'b0, 8'h56}) begin
      errors++; $display("FAIL read_hold: got %b_%h expected 0_56", p1_done, p1_rdata);
    end
  endtask

  task automatic test_drop();
    logic [25:0] e;
    int c0;
    c0 = exec_cnt;
    @(posedge clk); #1;
    drive_cmd(1'b0, 16'h3500, 8'h11, 1'b0);
    exp_q.push_back({1'b0, 1'b0, 16'h3500, 8'h11});
    @(posedge clk); #1;
    drive_cmd(1'b0, 16'h3600, 8'h22, 1'b1);
    @(negedge clk);
    checks++;
    if ({p0_busy, p0_err} !== 2'b10) begin
      errors++; $display("FAIL drop_busy: got %b expected 10", {p0_busy, p0_err});
    end
    @(posedge clk); #1;
    clear_exec();
    @(negedge clk);
    checks++;
    if ({p0_err, i2c_exec} !== 2'b11) begin
      errors++; $display("FAIL drop_err: got %b expected 11", {p0_err, i2c_exec});
    end
    pop_exp(e);
    checks++;
    if ({i2c_rh_wl, i2c_addr, i2c_data_w} !== e[24:0]) begin
      errors++; $display("FAIL drop_orig: got %h expected %h",
                         {i2c_rh_wl, i2c_addr, i2c_data_w}, e[24:0]);
    end
    finish_txn(10, 8'h33);
    checks++;
    if ({p0_done, p0_err, p0_rdata} !== {2'b10, 8'h33}) begin
      errors++; $display("FAIL drop_done: got %b_%h expected 10_33", {p0_done, p0_err}, p0_rdata);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (exec_cnt - c0 !== 1) begin
      errors++; $display("FAIL drop_exec_count: got %0d expected 1", exec_cnt - c0);
    end
  endtask

  // New start on the port that is completing, issued in its DONE cycle.
  task automatic test_back_to_back();
    logic [25:0] e;
    logic [24:0] seen;
    issue(1'b0, 16'h3700, 8'h44, 1'b0);
    serve(4, 8'h00, seen);
    pop_exp(e);
    checks++;
    if ({p0_done, p0_busy} !== 2'b10) begin
      errors++; $display("FAIL b2b_first_done: got %b expected 10", {p0_done, p0_busy});
    end
    drive_cmd(1'b0, 16'h3701, 8'h45, 1'b0);
    exp_q.push_back({1'b0, 1'b0, 16'h3701, 8'h45});
    @(posedge clk); #1;
    clear_exec();
    @(negedge clk);
    checks++;
    if ({p0_busy, p0_err} !== 2'b10) begin
      errors++; $display("FAIL b2b_accept: got %b expected 10", {p0_busy, p0_err});
    end
    serve(3, 8'h99, seen);
    pop_exp(e);
    checks++;
    if (seen !== e[24:0]) begin
      errors++; $display("FAIL b2b_fields: got %h expected %h", seen, e[24:0]);
    end
    checks++;
    if ({p0_done, p0_rdata} !== {1'b1, 8'h99}) begin
      errors++; $display("FAIL b2b_done: got %b_%h expected 1_99", p0_done, p0_rdata);
    end
  endtask

  task automatic test_done_ignored();
    repeat (2) @(posedge clk);
    #1;
    i2c_done = 1'b1; i2c_data_r = 8'hEE;
    @(posedge clk); #1;
    i2c_done = 1'b0;
    @(negedge clk);
    checks++;
    if ({p0_done, p1_done, dbg_state, p1_rdata, p0_rdata} !== {4'b0000, 8'h56, 8'h99}) begin
      errors++; $display("FAIL ignored_done: got %b_%h_%h expected 0000_56_99",
                         {p0_done, p1_done, dbg_state}, p1_rdata, p0_rdata);
    end
  endtask

`ifdef OV5640_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [25:0] e;
    logic [24:0] seen;
    int n;
    issue(1'b0, 16'h3800, 8'h55, 1'b1);
    wait_exec(seen);
    pop_exp(e);
    checks++;
    if (seen !== e[24:0]) begin
      errors++; $display("FAIL to_fields: got %h expected %h", seen, e[24:0]);
    end
    n = 0;
    for (int i = 1; i <= 300 && n == 0; i++) begin
      @(negedge clk);
      if (p0_done === 1'b1) n = i;
    end
    checks++;
    if (n !== 101) begin
      errors++; $display("FAIL to_latency: got %0d expected 101", n);
    end
    checks++;
    if ({p0_err, p0_rdata} !== {1'b1, 8'h00}) begin
      errors++; $display("FAIL to_err_rdata: got %b_%h expected 1_00", p0_err, p0_rdata);
    end
    @(negedge clk);
    checks++;
    if ({dbg_state, p0_busy} !== 3'b000) begin
      errors++; $display("FAIL to_idle: got %b expected 000", {dbg_state, p0_busy});
    end
  endtask
`endif

  task automatic test_reset_mid();
    logic [25:0] e;
    logic [24:0] seen;
    issue(1'b0, 16'h3900, 8'h66, 1'b0);
    wait_exec(seen);
    pop_exp(e);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (dbg_state !== 2'd2) begin
      errors++; $display("FAIL rstmid_in_wait: got %0d expected 2", dbg_state);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({dbg_state, p0_busy, i2c_addr, i2c_data_w, p0_rdata, p1_rdata} !== 43'h0) begin
      errors++; $display("FAIL rstmid_async: got %h expected 0",
                         {dbg_state, p0_busy, i2c_addr, i2c_data_w, p0_rdata, p1_rdata});
    end
    @(negedge clk);
    rst = 1'b0;
    rr_m = 1'b0;
    exp_q.delete();
    issue(1'b1, 16'h3503, 8'h03, 1'b0);
    serve(8, 8'h00, seen);
    pop_exp(e);
    checks++;
    if (seen !== e[24:0]) begin
      errors++; $display("FAIL rstmid_fields: got %h expected %h", seen, e[24:0]);
    end
    checks++;
    if ({p1_done, p1_busy, p0_done} !== 3'b100) begin
      errors++; $display("FAIL rstmid_done: got %b expected 100", {p1_done, p1_busy, p0_done});
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_write();
    test_arb(1'b0, "prio");
    test_arb(1'b1, "rr_a");
    test_arb(1'b1, "rr_b");
    test_read();
    test_drop();
    test_back_to_back();
    test_done_ignored();
`ifdef OV5640_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
